// File: rtl/dmem_arbiter.sv
// Two-port req/ack arbiter and access sequencer for the single-port data memory.
// Build option: define DMEM_ARB_RR_EN for round-robin arbitration (fixed port-0 priority otherwise).
module dmem_arbiter #(
  parameter int MemSize = 20
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Req0,
  input  logic        Req1,
  input  logic        We0,
  input  logic        We1,
  input  logic [63:0] Addr0,
  input  logic [63:0] Addr1,
  input  logic [63:0] WData0,
  input  logic [63:0] WData1,
  output logic        Ack0,
  output logic        Ack1,
  output logic [63:0] RData0,
  output logic [63:0] RData1,
  output logic        Err0,
  output logic        Err1,
  output logic        MemEn,
  output logic        MemWe,
  output logic [63:0] MemAddr,
  output logic [63:0] MemWData,
  input  logic [63:0] MemRData,
  output logic        Busy
);

  // Handshake: a requester holds Req/We/Addr/WData stable until its one-cycle
  // Ack; a request is taken only in IDLE, and Ack fires even if Req drops after the grant.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [63:0] Limit = 64'(MemSize);

  state_t      state, state_next;
  logic        win_q, we_q, err_q;
  logic [63:0] addr_q, wdata_q;
  logic        grant, grant_id;
  logic        in_range;
  logic [63:0] rdata;

  assign grant    = (state == IDLE) && (Req0 || Req1);
  assign in_range = addr_q < Limit;

`ifdef DMEM_ARB_RR_EN
  logic rr_ptr;

  // Pointer names the port preferred on a tie and flips away from each winner.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)     rr_ptr <= 1'b0;
    else if (grant) rr_ptr <= ~grant_id;
  end

  always_comb begin
    grant_id = 1'b0;
    if (Req0 && Req1) grant_id = rr_ptr;
    else              grant_id = Req1;
  end
`else
  always_comb begin
    grant_id = ~Req0;
  end
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= IDLE;
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_next;
      if (grant) begin
        win_q   <= grant_id;
        we_q    <= grant_id ? We1 : We0;
        addr_q  <= grant_id ? Addr1 : Addr0;
        wdata_q <= grant_id ? WData1 : WData0;
      end
      if (state == ACCESS) err_q <= ~in_range;
    end
  end

  always_comb begin
    state_next = state;
    Ack0       = 1'b0;
    Ack1       = 1'b0;
    RData0     = '0;
    RData1     = '0;
    Err0       = 1'b0;
    Err1       = 1'b0;
    MemEn      = 1'b0;
    MemWe      = 1'b0;
    MemAddr    = '0;
    MemWData   = '0;
    rdata      = (!we_q && !err_q) ? MemRData : '0;
    case (state)
      IDLE: begin
        if (grant) state_next = ACCESS;
      end
      ACCESS: begin
        if (in_range) begin
          MemEn    = 1'b1;
          MemWe    = we_q;
          MemAddr  = addr_q;
          MemWData = wdata_q;
        end
        state_next = RESP;
      end
      RESP: begin
        if (win_q) begin
          Ack1   = 1'b1;
          RData1 = rdata;
          Err1   = err_q;
        end else begin
          Ack0   = 1'b1;
          RData0 = rdata;
          Err0   = err_q;
        end
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign Busy = (state != IDLE);

endmodule
